// File: rtl/cache_way_ctrl.sv
// Lookup/replacement controller for a 4-way set-associative cache.
// Compares the four stored tags, picks a hit or victim way, and keeps per-set tree PLRU bits.
module cache_way_ctrl #(
    parameter int WAYS  = 4,
    parameter int SETS  = 64,
    parameter int TAG_W = 20
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [$clog2(SETS)-1:0]  i_req_idx,
    input  logic [TAG_W-1:0]         i_req_tag,
    output logic                     o_tag_rd_en,
    output logic [$clog2(SETS)-1:0]  o_tag_rd_idx,
    input  logic [WAYS*TAG_W-1:0]    i_tag_way,
    input  logic [WAYS-1:0]          i_valid_way,
    output logic                     o_resp_valid,
    input  logic                     i_resp_ready,
    output logic                     o_hit,
    output logic [WAYS-1:0]          o_way_sel,
    output logic [WAYS-1:0]          o_victim_sel,
    output logic                     o_multi_hit,
    input  logic                     i_flush,
    output logic                     o_flush_done
);
    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP, S_FLUSH} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic               r_hit;
    logic [WAYS-1:0]    r_way_sel;
    logic [WAYS-1:0]    r_victim_sel;
    logic               r_multi_hit;
    logic [IDX_W-1:0]   r_flush_cnt;
    logic [2:0]         r_plru [SETS];

    logic               w_accept;
    logic               w_flush_last;
    logic [WAYS-1:0]    w_match;
    logic [WAYS-1:0]    w_hit_sel;
    logic [WAYS-1:0]    w_invalid;
    logic [WAYS-1:0]    w_victim;
    logic [WAYS-1:0]    w_plru_victim;
    logic [1:0]         w_plru_way;
    logic [2:0]         w_plru_rd;
    logic [2:0]         w_plru_upd;
    logic [WAYS-1:0]    w_used;
    logic               w_plru_we;
    logic [IDX_W-1:0]   w_plru_widx;
    logic [2:0]         w_plru_wdata;

    assign o_req_ready  = (r_state == S_IDLE) & ~i_flush;
    assign w_accept     = o_req_ready & i_req_valid;
    assign o_tag_rd_en  = w_accept;
    assign o_tag_rd_idx = w_accept ? i_req_idx : '0;
    assign o_resp_valid = (r_state == S_RESP);
    assign w_flush_last = (r_flush_cnt == IDX_W'(SETS - 1));
    assign o_flush_done = (r_state == S_FLUSH) & w_flush_last;

    assign o_hit        = r_hit;
    assign o_way_sel    = r_way_sel;
    assign o_victim_sel = r_victim_sel;
    assign o_multi_hit  = r_multi_hit;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_match
            assign w_match[gi] = i_valid_way[gi] & (i_tag_way[gi*TAG_W +: TAG_W] == r_tag);
        end
    endgenerate

    // x & -x isolates the lowest set bit: lowest-index hit or lowest-index invalid way.
    assign w_hit_sel = w_match & (~w_match + WAYS'(1));
    assign w_invalid = ~i_valid_way;

    assign w_plru_rd     = r_plru[r_idx];
    assign w_plru_way    = w_plru_rd[0] ? (w_plru_rd[2] ? 2'd3 : 2'd2)
                                        : (w_plru_rd[1] ? 2'd1 : 2'd0);
    assign w_plru_victim = WAYS'(1) << w_plru_way;
    assign w_victim      = (&i_valid_way) ? w_plru_victim
                                          : (w_invalid & (~w_invalid + WAYS'(1)));

    assign w_used = r_hit ? r_way_sel : r_victim_sel;

    always_comb begin
        w_plru_upd = w_plru_rd;
        if (w_used[0]) begin
            w_plru_upd[0] = 1'b1;
            w_plru_upd[1] = 1'b1;
        end else if (w_used[1]) begin
            w_plru_upd[0] = 1'b1;
            w_plru_upd[1] = 1'b0;
        end else if (w_used[2]) begin
            w_plru_upd[0] = 1'b0;
            w_plru_upd[2] = 1'b1;
        end else if (w_used[3]) begin
            w_plru_upd[0] = 1'b0;
            w_plru_upd[2] = 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_plru_we    = 1'b0;
        w_plru_widx  = r_idx;
        w_plru_wdata = w_plru_upd;
        case (r_state)
            S_IDLE: begin
                if (i_flush) begin
                    w_state_next = S_FLUSH;
                end else if (i_req_valid) begin
                    w_state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: w_state_next = S_RESP;
            S_RESP: begin
                if (i_resp_ready) begin
                    w_plru_we    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                w_plru_we    = 1'b1;
                w_plru_widx  = r_flush_cnt;
                w_plru_wdata = 3'b000;
                if (w_flush_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_tag        <= '0;
            r_hit        <= 1'b0;
            r_way_sel    <= '0;
            r_victim_sel <= '0;
            r_multi_hit  <= 1'b0;
            r_flush_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_idx <= i_req_idx;
                r_tag <= i_req_tag;
            end
            if (r_state == S_LOOKUP) begin
                r_hit        <= |w_match;
                r_way_sel    <= w_hit_sel;
                r_victim_sel <= (|w_match) ? '0 : w_victim;
                r_multi_hit  <= (w_match & (w_match - WAYS'(1))) != '0;
            end
            // Wraps back to 0 on the last set, ready for the next flush.
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SETS; i++) begin
                r_plru[i] <= 3'b000;
            end
        end else if (w_plru_we) begin
            r_plru[w_plru_widx] <= w_plru_wdata;
        end
    end
endmodule

// File: tb/tb_cache_way_ctrl.sv
// Bench for cache_way_ctrl: directed scenarios plus randomized lookups against a tree-PLRU model.
module tb_cache_way_ctrl;
    localparam int WAYS = 4;
    localparam int SETS = 64;
    localparam int TAG_W = 20;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [5:0]         req_idx = '0;
    logic [TAG_W-1:0]   req_tag = '0;
    logic               tag_rd_en;
    logic [5:0]         tag_rd_idx;
    logic [WAYS*TAG_W-1:0] tag_way = '0;
    logic [WAYS-1:0]    valid_way = '0;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic               hit;
    logic [WAYS-1:0]    way_sel;
    logic [WAYS-1:0]    victim_sel;
    logic               multi_hit;
    logic               flush = 1'b0;
    logic               flush_done;

    int checks = 0;
    int errors = 0;

    // Model: per-set tree bits kept as three separate flags.
    bit m_b0 [SETS];
    bit m_b1 [SETS];
    bit m_b2 [SETS];

    logic           e_hit;
    logic           e_multi;
    logic [3:0]     e_way;
    logic [3:0]     e_vic;
    int             e_used;
    int             e_idx;

    always #5 clk = ~clk;

    cache_way_ctrl #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_idx(req_idx), .i_req_tag(req_tag),
        .o_tag_rd_en(tag_rd_en), .o_tag_rd_idx(tag_rd_idx),
        .i_tag_way(tag_way), .i_valid_way(valid_way),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_hit(hit), .o_way_sel(way_sel), .o_victim_sel(victim_sel),
        .o_multi_hit(multi_hit),
        .i_flush(flush), .o_flush_done(flush_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WAYS*TAG_W-1:0] pack4(input logic [TAG_W-1:0] t0, t1, t2, t3);
        return {t3, t2, t1, t0};
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_b0[s] = 0; m_b1[s] = 0; m_b2[s] = 0;
        end
    endtask

    // Issue a request and check the result once RESP is reached.
    task automatic issue(input int idx, input logic [TAG_W-1:0] tag,
                         input logic [WAYS*TAG_W-1:0] tw, input logic [3:0] vw, input string name);
        int nhit;
        int first;
        @(posedge clk); #1;
        req_valid = 1'b1; req_idx = 6'(idx); req_tag = tag;
        @(negedge clk);
        check({name, ".ready"}, req_ready, 1);
        check({name, ".rd_en"}, tag_rd_en, 1);
        check({name, ".rd_idx"}, tag_rd_idx, idx);
        @(posedge clk); #1;
        req_valid = 1'b0; tag_way = tw; valid_way = vw;
        @(negedge clk);
        check({name, ".lookup_rd_en"}, tag_rd_en, 0);
        check({name, ".lookup_rv"}, resp_valid, 0);
        @(posedge clk); #1;
        tag_way = '0; valid_way = '0;
        nhit = 0; first = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (vw[w] && tw[w*TAG_W +: TAG_W] == tag) begin
                if (first < 0) first = w;
                nhit++;
            end
        end
        e_idx = idx;
        e_hit = (nhit > 0);
        e_multi = (nhit > 1);
        e_way = e_hit ? 4'(1 << first) : 4'b0;
        if (e_hit) begin
            e_used = first;
        end else if (vw != 4'hF) begin
            e_used = 0;
            while (vw[e_used]) e_used++;
        end else if (!m_b0[idx]) begin
            e_used = m_b1[idx] ? 1 : 0;
        end else begin
            e_used = m_b2[idx] ? 3 : 2;
        end
        e_vic = e_hit ? 4'b0 : 4'(1 << e_used);
        @(negedge clk);
        check({name, ".resp_valid"}, resp_valid, 1);
        check({name, ".hit"}, hit, e_hit);
        check({name, ".way_sel"}, way_sel, e_way);
        check({name, ".victim_sel"}, victim_sel, e_vic);
        check({name, ".multi_hit"}, multi_hit, e_multi);
    endtask

    // Stall for 'hold' cycles, then handshake and update the model.
    task automatic complete(input int hold, input string name);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, ".hold_rv"}, resp_valid, 1);
            check({name, ".hold_ready"}, req_ready, 0);
            check({name, ".hold_way"}, way_sel, e_way);
            check({name, ".hold_vic"}, victim_sel, e_vic);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        case (e_used)
            0: begin m_b0[e_idx] = 1; m_b1[e_idx] = 1; end
            1: begin m_b0[e_idx] = 1; m_b1[e_idx] = 0; end
            2: begin m_b0[e_idx] = 0; m_b2[e_idx] = 1; end
            default: begin m_b0[e_idx] = 0; m_b2[e_idx] = 0; end
        endcase
        @(negedge clk);
        check({name, ".post_rv"}, resp_valid, 0);
        check({name, ".post_ready"}, req_ready, 1);
        $display("txn %s idx=%0d hit=%0b way=%b vic=%b multi=%0b", name, e_idx, e_hit, e_way, e_vic, e_multi);
    endtask

    task automatic lookup(input int idx, input logic [TAG_W-1:0] tag,
                          input logic [WAYS*TAG_W-1:0] tw, input logic [3:0] vw,
                          input int hold, input string name);
        issue(idx, tag, tw, vw, name);
        complete(hold, name);
    endtask

    logic [WAYS*TAG_W-1:0] tw_a;
    logic [TAG_W-1:0]      pool [4];

    initial begin
        int n;
        model_clear();
        tw_a = pack4(20'h10000, 20'h20000, 20'h30000, 20'h40000);
        pool[0] = 20'h00111; pool[1] = 20'h00222; pool[2] = 20'h00333; pool[3] = 20'h00444;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.resp_valid", resp_valid, 0);
        check("rst.tag_rd_en", tag_rd_en, 0);
        check("rst.tag_rd_idx", tag_rd_idx, 0);
        check("rst.hit", hit, 0);
        check("rst.way_sel", way_sel, 0);
        check("rst.victim_sel", victim_sel, 0);
        check("rst.multi_hit", multi_hit, 0);
        check("rst.flush_done", flush_done, 0);
        check("rst.req_ready", req_ready, 1);
        rst_n = 1'b1;

        lookup(5, 20'h30000, tw_a, 4'hF, 0, "hit_way2");
        lookup(3, 20'h55555, tw_a, 4'b1011, 0, "miss_inv2");
        for (int k = 0; k < 4; k++) lookup(7, 20'h77777, tw_a, 4'hF, 0, $sformatf("set7_miss%0d", k));
        lookup(9, 20'hABCDE, pack4(20'h1, 20'hABCDE, 20'h2, 20'hABCDE), 4'hF, 0, "multi_hit");
        lookup(5, 20'h99999, tw_a, 4'hF, 0, "set5_miss_a");
        lookup(5, 20'h99999, tw_a, 4'hF, 0, "set5_miss_b");
        lookup(11, 20'h20000, tw_a, 4'hF, 5, "hold5_hit");
        lookup(11, 20'h99999, tw_a, 4'hF, 0, "hold5_after");
        lookup(7, 20'h77777, tw_a, 4'hF, 0, "set7_pre_flush");

        // Flush wins over a simultaneous request.
        @(posedge clk); #1;
        flush = 1'b1; req_valid = 1'b1; req_idx = 6'd7;
        @(negedge clk);
        check("flush.req_ready", req_ready, 0);
        check("flush.rd_en", tag_rd_en, 0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (flush_done || n >= 200) break;
            n++;
            @(posedge clk); #1;
        end
        check("flush.cycles", n + 1, SETS);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush.done_pulse", flush_done, 0);
        check("flush.idle_ready", req_ready, 1);
        check("flush.no_resp", resp_valid, 0);
        $display("txn flush cycles=%0d", n + 1);
        model_clear();
        lookup(7, 20'h77777, tw_a, 4'hF, 0, "post_flush_miss");

        for (int r = 0; r < 40; r++) begin
            logic [WAYS*TAG_W-1:0] tw;
            logic [3:0] vw;
            tw = pack4(pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                       pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)]);
            vw = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            lookup(8 + $urandom_range(0, 3), pool[$urandom_range(0, 3)] ^ (($urandom_range(0, 2) == 0) ? 20'h8 : 20'h0),
                   tw, vw, $urandom_range(0, 2), $sformatf("rnd%0d", r));
        end

        // Asynchronous reset during RESP drops the response.
        issue(7, 20'h77777, tw_a, 4'hF, "rst_in_resp");
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_resp.resp_valid", resp_valid, 0);
        check("rst_in_resp.victim", victim_sel, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset_in_resp");
        lookup(7, 20'h77777, tw_a, 4'hF, 0, "post_reset_miss");
        lookup(7, 20'h77777, tw_a, 4'hF, 0, "post_reset_miss2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_way_ctrl.md
# cache_way_ctrl

Lookup and replacement controller for the 4-way set-associative cache. It accepts a lookup request and reads the per-set tag/valid entries from the tag RAM. It compares all four ways, drives the one-hot way select consumed by the line-data way multiplexer, and picks a victim way on a miss. It owns the tree pseudo-LRU state for every set and provides a sequential flush of that state.

## Interface
Parameters:
- WAYS, 4, number of ways; tree PLRU requires exactly 4
- SETS, 64, number of sets; power of two
- TAG_W, 20, tag width in bits

Ports:
- i_clk  in  1  single clock; all state on the rising edge
- i_rst_n  in  1  reset, asynchronous and active-low
- i_req_valid  in  1  lookup request valid
- o_req_ready  out  1  controller can accept a request
- i_req_idx  in  $clog2(SETS)  set index
- i_req_tag  in  TAG_W  lookup tag
- o_tag_rd_en  out  1  tag RAM read strobe; data returns 1 cycle later
- o_tag_rd_idx  out  $clog2(SETS)  tag RAM read index
- i_tag_way  in  WAYS*TAG_W  stored tags, way w at bits [w*TAG_W +: TAG_W]
- i_valid_way  in  WAYS  per-way valid bits
- o_resp_valid  out  1  lookup result valid
- i_resp_ready  in  1  consumer accepts the result
- o_hit  out  1  result is a hit
- o_way_sel  out  WAYS  one-hot hit way; drives the way mux select; 0 on miss
- o_victim_sel  out  WAYS  one-hot victim way; 0 on hit
- o_multi_hit  out  1  more than one way matched (error flag)
- i_flush  in  1  request a PLRU flush
- o_flush_done  out  1  one-cycle pulse when the flush completes

## Operation
- States are IDLE, LOOKUP, RESP and FLUSH. Reset enters IDLE.
- o_req_ready = (state==IDLE) & ~i_flush. It is combinational, so it reads 1 while in reset.
- IDLE:
  - If i_flush=1, go to FLUSH. Flush has priority over a simultaneous request; the request is not accepted.
  - Else if i_req_valid=1, accept the request. Pulse o_tag_rd_en=1, drive o_tag_rd_idx=i_req_idx, capture the index and tag, and go to LOOKUP.
- LOOKUP:
  - match[w] = i_valid_way[w] & (i_tag_way[w]==captured tag).
  - Hit: o_way_sel gets the lowest-index set bit of match. o_multi_hit = popcount(match)>1.
  - Miss with any invalid way: victim is the lowest-index invalid way.
  - Miss with all ways valid: victim comes from the PLRU bits {b2,b1,b0} of the set. b0=0 selects b1 (way0 if b1=0, else way1). b0=1 selects b2 (way2 if b2=0, else way3).
  - Register all results and go to RESP.
- RESP:
  - Hold o_resp_valid=1 with stable outputs until i_resp_ready=1.
  - On the handshake, update the set's PLRU bits to mark the used way as MRU. The used way is the hit way, or the victim on a miss.
  - MRU update values: way0 sets b0=1,b1=1. Way1 sets b0=1,b1=0. Way2 sets b0=0,b2=1. Way3 sets b0=0,b2=0. Other bits are unchanged.
  - Then go to IDLE.
- FLUSH:
  - The PLRU array has one write port. A counter walks sets 0..SETS-1 and clears one set's bits per cycle.
  - On the last set, pulse o_flush_done and go to IDLE.
  - i_flush is ignored while already in FLUSH.
- The tag RAM is read-only to this block. Fills and valid-bit updates are handled elsewhere.

## Timing
- Reset values:
  - State is IDLE. The PLRU array is all 0, so the first full-set victim is way0.
  - o_tag_rd_en, o_resp_valid, o_hit, o_way_sel, o_victim_sel, o_multi_hit and o_flush_done are all 0.
  - o_tag_rd_idx is 0.
  - The flush counter is 0.
- Latency: request accepted in cycle N, tag data sampled in cycle N+1, o_resp_valid=1 from cycle N+2.
- Back-to-back: a new request can be accepted the cycle after the RESP handshake. Best-case throughput is one lookup per 3 cycles.
- A PLRU write from RESP is visible to a lookup of the same set that reads PLRU in a later LOOKUP. No bypass is needed, because the two never overlap.
- Flush takes exactly SETS cycles in FLUSH. o_flush_done asserts in the last of those cycles.
- Reset mid-operation: an asynchronous return to IDLE. Any pending response is dropped with no PLRU update. A flush in progress is abandoned, but the reset itself clears the array.

## Test plan
- Reset, then a request with idx=5 on a tag equal to way2, all valid -> o_tag_rd_en pulses in cycle 0, o_resp_valid in cycle 2 with o_hit=1, o_way_sel=4'b0100, o_victim_sel=0. After the handshake, PLRU[5] = b0=0, b2=1.
- Miss on set 3 with i_valid_way=4'b1011 -> o_hit=0, o_victim_sel=4'b0100, o_way_sel=0.
- Four misses on set 7, all ways valid, from reset -> victims in order way0, way2, way1, way3.
- Tag matches both way1 and way3 -> o_way_sel=4'b0010, o_multi_hit=1.
- Hold i_resp_ready low for 5 cycles in RESP -> outputs stay stable, o_req_ready=0, and the PLRU is updated only on the handshake.
- i_flush and i_req_valid asserted together in IDLE -> request not accepted, o_flush_done after SETS=64 cycles, next full-set miss victim is way0. Assert i_rst_n=0 during a later RESP -> o_resp_valid drops to 0 immediately.
